// File: rtl/adc_temp_reader_if.sv
// ADC reader bus: control input, ADC serial lines and the temperature result.
// The slave modport is the reader itself; master is whoever drives/observes it.
interface adc_temp_reader_if;
  logic       start_en;
  logic       sdata;
  logic       sclk;
  logic       cs_n;
  logic [6:0] temp;
  logic       temp_valid;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  start_en, sdata,
    output sclk, cs_n, temp, temp_valid, frame_err, busy
  );

  modport master (
    output start_en, sdata,
    input  sclk, cs_n, temp, temp_valid, frame_err, busy
  );
endinterface

// File: rtl/adc_temp_reader.sv
// Periodic 12-bit serial ADC reader producing a 7-bit temperature code.
// Frame: 16 SCLK periods, 4 leading zeros then 12 data bits MSB first.
// Optional feature macro TEMP_AVG_EN: average 4 good samples per temp update.
module adc_temp_reader #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 100000
) (
  input  logic             clock,
  input  logic             clr,
  adc_temp_reader_if.slave bus_io
);
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = $clog2(CLK_DIV) + 1;
  localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_QUIET, UPDATE} state_t;

  state_t        state_q;
  logic [PW-1:0] per_q, per_d;
  logic          trig;
  logic [TW-1:0] tick_q;
  logic          tick_last;
  logic [4:0]    half_q;     // SCLK half-period index within SHIFT
  logic [15:0]   shift_q;
  logic          cs_n_q, sclk_q, tv_q, fe_q;
  logic [6:0]    temp_q;

`ifdef TEMP_AVG_EN
  logic [13:0] sum_q, sum_nx;
  logic [1:0]  cnt_q;
  assign sum_nx = sum_q + {2'b00, shift_q[11:0]};
`else
  // Low data bits are truncated away when not averaging.
  logic unused_lsbs;
  assign unused_lsbs = ^shift_q[4:0];
`endif

  // Period counter next state and trigger; held at zero while disabled.
  always_comb begin
    trig = bus_io.start_en && (per_q == PER_LAST);
    if (!bus_io.start_en || per_q == PER_LAST) per_d = '0;
    else                                       per_d = per_q + 1'b1;
  end

  assign tick_last = (tick_q == TICK_LAST);

  // Sample period counter.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) per_q <= '0;
    else     per_q <= per_d;
  end

  // Conversion FSM: chip select, SCLK generation, shifting and result update.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      temp_q  <= '0;
      tv_q    <= 1'b0;
      fe_q    <= 1'b0;
      tick_q  <= '0;
      half_q  <= '0;
      shift_q <= '0;
`ifdef TEMP_AVG_EN
      sum_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      tv_q <= 1'b0;
      fe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Triggers arriving in any other state are simply ignored.
          if (trig) begin
            state_q <= CS_SETUP;
            cs_n_q  <= 1'b0;
            tick_q  <= '0;
          end
        end
        CS_SETUP: begin
          if (tick_last) begin
            state_q <= SHIFT;
            sclk_q  <= 1'b0;
            tick_q  <= '0;
            half_q  <= '0;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        SHIFT: begin
          if (tick_last) begin
            tick_q <= '0;
            if (half_q == 5'd31) begin
              // Last high half done: SCLK stays high, release chip select.
              state_q <= CS_QUIET;
              cs_n_q  <= 1'b1;
            end else begin
              half_q <= half_q + 1'b1;
              sclk_q <= ~sclk_q;
              if (!sclk_q) shift_q <= {shift_q[14:0], bus_io.sdata};
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        CS_QUIET: begin
          if (tick_last) begin
            state_q <= UPDATE;
            tick_q  <= '0;
            // Result registered here so the pulse is seen during UPDATE.
            if (shift_q[15:12] != 4'd0) begin
              fe_q <= 1'b1;
            end else begin
`ifdef TEMP_AVG_EN
              if (cnt_q == 2'd3) begin
                temp_q <= sum_nx[13:7];
                tv_q   <= 1'b1;
                sum_q  <= '0;
                cnt_q  <= '0;
              end else begin
                sum_q <= sum_nx;
                cnt_q <= cnt_q + 1'b1;
              end
`else
              temp_q <= shift_q[11:5];
              tv_q   <= 1'b1;
`endif
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        UPDATE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.cs_n       = cs_n_q;
  assign bus_io.sclk       = sclk_q;
  assign bus_io.temp       = temp_q;
  assign bus_io.temp_valid = tv_q;
  assign bus_io.frame_err  = fe_q;
  assign bus_io.busy       = (state_q != IDLE);
endmodule
